// File: rtl/mydebounce_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mydebounce_if : switch input and conditioned outputs of mydebounce
// Revision      : 1.0
// ---------------------------------------------------------------------------
interface mydebounce_if;
  logic D;
  logic Q;
  logic RISE;
  logic FALL;
  logic BUSY;

  modport master (
    output D,
    input  Q,
    input  RISE,
    input  FALL,
    input  BUSY
  );

  modport slave (
    input  D,
    output Q,
    output RISE,
    output FALL,
    output BUSY
  );
endinterface
`default_nettype wire

// File: rtl/mydebounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mydebounce : synchronizer + stability-qualified level filter with edge pulses
// Revision   : 1.0
// ---------------------------------------------------------------------------
module mydebounce #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000,
  parameter int CNT_WIDTH   = 16
) (
  input  wire           CLK,
  input  wire           RST,
  mydebounce_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_terminal = CNT_WIDTH'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync  = '0;
  state_t                 r_state = ST_STABLE_LO;
  logic [CNT_WIDTH-1:0]   r_cnt   = '0;
  logic                   r_q     = 1'b0;
  logic                   r_rise  = 1'b0;
  logic                   r_fall  = 1'b0;
  logic                   r_busy  = 1'b0;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // The old-level check precedes the terminal compare, so a bounce on the
  // final qualifying cycle is still rejected; the compare precedes the
  // increment, so the counter cannot wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync  <= '0;
      r_state <= ST_STABLE_LO;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.D};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE_LO: begin
          if (w_s) begin
            r_state <= ST_WAIT_HI;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (!w_s) begin
            r_state <= ST_STABLE_LO;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_terminal) begin
            r_state <= ST_STABLE_HI;
            r_q     <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STABLE_HI: begin
          if (!w_s) begin
            r_state <= ST_WAIT_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (w_s) begin
            r_state <= ST_STABLE_HI;
            r_busy  <= 1'b0;
          end else if (r_cnt == c_terminal) begin
            r_state <= ST_STABLE_LO;
            r_q     <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_STABLE_LO;
          r_cnt   <= '0;
          r_q     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.RISE = r_rise;
  assign bus.FALL = r_fall;
  assign bus.BUSY = r_busy;

endmodule
`default_nettype wire
